fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch from the instruction ROM
//  in the pipelined core. Drives the ROM address, registers the fetched PC into the
//  IF/ID stage, applies stalls from the hazard unit and redirects from execute, and

---
 rtl/fetch_sequencer_pkg.sv | 30 +++
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions used by the fetch sequencer: opcode constants,
// instruction format codes and the fetch state encoding.
package fetch_sequencer_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [3:0] HALT_OP = 4'b1110;
    localparam logic [3:0] BEQ_OP  = 4'b1000;
    localparam logic [3:0] BNE_OP  = 4'b1001;
    localparam logic [3:0] JMP_OP  = 4'b1010;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_B,
        FMT_J
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } fetch_state_e;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == BEQ_OP) || (op == BNE_OP) || (op == JMP_OP);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: control inputs from hazard/execute, the ROM port and the
// IF/ID stage outputs. master = sequencer, slave = surrounding core.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            start;
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [3:0]      rom_opcode;
    logic [PC_W-1:0] rom_pc;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
    logic            running;
    logic            halted;
    logic [15:0]     fetch_cnt;

    modport master (
        input  start, stall, br_taken, br_target, rom_opcode,
        output rom_pc, id_pc, id_valid, running, halted, fetch_cnt
    );

    modport slave (
        output start, stall, br_taken, br_target, rom_opcode,
        input  rom_pc, id_pc, id_valid, running, halted, fetch_cnt
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner: fetches from the instruction ROM into IF/ID, honours
// stalls and branch redirects, and drains the pipeline after a HALT fetch.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] START_PC  = '0,
    parameter int              DRAIN_CYC = 3
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);

    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] id_pc_p0;
    logic            vld_p0;
    logic            running;
    logic            halted;
    logic [15:0]     fetch_cnt;
    logic [DW-1:0]   drain_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= START_PC;
            id_pc_p0  <= '0;
            vld_p0    <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            fetch_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vld_p0 <= 1'b0;
                    pc     <= START_PC;
                    if (bus.start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // Redirect beats stall; stall beats HALT detection.
                    if (bus.br_taken) begin
                        pc     <= bus.br_target;
                        vld_p0 <= 1'b0;
                    end else if (!bus.stall) begin
                        id_pc_p0  <= pc;
                        vld_p0    <= 1'b1;
                        fetch_cnt <= sat_inc(fetch_cnt);
                        if (bus.rom_opcode == HALT_OP) begin
                            drain_cnt <= DW'(DRAIN_CYC);
                            state     <= DRAIN;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    vld_p0 <= 1'b0;
                    // A taken branch here is older than the HALT, so execution resumes.
                    if (bus.br_taken) begin
                        pc    <= bus.br_target;
                        state <= RUN;
                    end else if (!bus.stall) begin
                        drain_cnt <= (drain_cnt == '0) ? '0 : drain_cnt - DW'(1);
                        if (drain_cnt <= DW'(1)) begin
                            state   <= HALTED;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    vld_p0 <= 1'b0;
                    if (bus.start) begin
                        pc        <= START_PC;
                        fetch_cnt <= '0;
                        state     <= RUN;
                        running   <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_pc    = pc;
    assign bus.id_pc     = id_pc_p0;
    assign bus.id_valid  = vld_p0;
    assign bus.running   = running;
    assign bus.halted    = halted;
    assign bus.fetch_cnt = fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by random
// traffic, expected outputs produced by a behavioural model of the fetch rules.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int          DRAIN = 3;
    localparam logic [15:0] SPC   = 16'h0000;

    typedef struct packed {
        logic [15:0] rom_pc;
        logic [15:0] id_pc;
        logic        id_valid;
        logic        running;
        logic        halted;
        logic [15:0] fetch_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(16)) bus();

    fetch_sequencer #(
        .PC_W(16),
        .START_PC(SPC),
        .DRAIN_CYC(DRAIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [3:0] rom [0:255];
    assign bus.rom_opcode = rom[bus.rom_pc[7:0]];

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: mode 0 idle, 1 run, 2 drain, 3 halted; drain_left = cycles still to wait
    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_id_pc;
    logic        m_vld;
    logic [15:0] m_cnt;
    int          m_drain_left;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, got, want);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic st,
                        input logic b, input logic [15:0] t);
        logic [3:0] op;
        exp_t e;
        @(negedge clk);
        reset         = r;
        bus.start     = s;
        bus.stall     = st;
        bus.br_taken  = b;
        bus.br_target = t;
        op = rom[m_pc[7:0]];
        if (r) begin
            m_mode = 0; m_pc = SPC; m_id_pc = 16'h0; m_vld = 1'b0;
            m_cnt = 16'h0; m_drain_left = 0;
        end else if (m_mode == 0) begin
            m_vld = 1'b0;
            m_pc  = SPC;
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (b) begin
                m_pc  = t;
                m_vld = 1'b0;
            end else if (!st) begin
                m_id_pc = m_pc;
                m_vld   = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (op == 4'b1110) begin
                    m_mode = 2;
                    m_drain_left = DRAIN;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end
        end else if (m_mode == 2) begin
            m_vld = 1'b0;
            if (b) begin
                m_pc = t;
                m_mode = 1;
            end else if (!st) begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left <= 0) m_mode = 3;
            end
        end else begin
            m_vld = 1'b0;
            if (s) begin
                m_pc = SPC; m_cnt = 16'h0; m_mode = 1;
            end
        end
        e.rom_pc    = m_pc;
        e.id_pc     = m_id_pc;
        e.id_valid  = m_vld;
        e.running   = (m_mode == 1) || (m_mode == 2);
        e.halted    = (m_mode == 3);
        e.fetch_cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic nstep();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic run_until_pc(input logic [15:0] target);
        int n = 0;
        while (m_pc != target && n < 200) begin
            nstep();
            n++;
        end
        checks++;
        if (m_pc != target) begin
            errors++;
            $display("FAIL reach_pc cyc=%0d got %h expected %h", cyc, m_pc, target);
        end
    endtask

    task automatic run_until_mode(input int mode);
        int n = 0;
        while (m_mode != mode && n < 200) begin
            nstep();
            n++;
        end
        checks++;
        if (m_mode != mode) begin
            errors++;
            $display("FAIL reach_mode cyc=%0d got %0d expected %0d", cyc, m_mode, mode);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rom_pc",    bus.rom_pc,           e.rom_pc);
            chk("id_pc",     bus.id_pc,            e.id_pc);
            chk("id_valid",  {15'h0, bus.id_valid}, {15'h0, e.id_valid});
            chk("running",   {15'h0, bus.running},  {15'h0, e.running});
            chk("halted",    {15'h0, bus.halted},   {15'h0, e.halted});
            chk("fetch_cnt", bus.fetch_cnt,        e.fetch_cnt);
        end
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 16'h0;
        for (int i = 0; i < 256; i++) rom[i] = 4'h0;
        m_mode = 0; m_pc = SPC; m_id_pc = 16'h0; m_vld = 1'b0; m_cnt = 16'h0; m_drain_left = 0;

        // Reset, idle, then straight-line fetch with a 2-cycle stall at pc 5
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        nstep();
        nstep();
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        run_until_pc(16'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // HALT at pc 7, drain to HALTED, stall during drain, start ignored while running
        rom[7] = HALT_OP;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        run_until_mode(2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_until_mode(3);
        nstep();
        nstep();

        // Restart; branch during DRAIN back to pc 2
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        run_until_mode(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        nstep();
        run_until_mode(2);
        run_until_mode(3);

        // Restart; stall on HALT then branch over HALT; branch at pc 10 to 40
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        run_until_pc(16'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
        rom[7] = 4'h0;
        run_until_pc(16'd10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd40);
        nstep();
        nstep();

        // PC wrap at 16'hFFFF, then reset in the middle of DRAIN
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        nstep();
        nstep();
        rom[3] = HALT_OP;
        run_until_mode(2);
        nstep();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        nstep();
        rom[3] = 4'h0;

        // Random traffic
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? HALT_OP : 4'($urandom_range(0, 15) & 4'hD);
        for (int i = 0; i < 4000; i++) begin
            logic r, s, st, b;
            logic [15:0] t;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 7) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                             : 16'($urandom_range(0, 255));
            step(r, s, st, b, t);
        end
        nstep();
        nstep();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain cyc=%0d got %0d expected 0", cyc, q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
